mult_seq_ctrl: RTL and testbench
================================

Name: mult_seq_ctrl

Overview:
- Sequencer for the shift-add multiplier datapath (multiplicand register, product/multiplier shift register, adder).
- Accepts a start request, loads operands, and runs WIDTH test/add/shift iterations using an internal iteration counter, so no external is_32 signal is needed.
- Presents the result with a done/ack handshake.
- Sits between the CPU-side issue logic and the multiplier datapath control inputs.

Parameters:
- WIDTH, 32, operand width; number of test/shift iterations. Legal range WIDTH >= 2.
- CNT_W, 5, iteration counter width; must satisfy 2**CNT_W >= WIDTH.

Ports:
- clk  input  1  rising-edge clock
- clr  input  1  synchronous active-high reset
- start  input  1  request a multiply; accepted only when ready=1
- ack  input  1  consumer has taken the result; honoured only in DONE
- abort  input  1  cancel the operation in progress; return to IDLE
- product_0  input  1  LSB of the datapath product register
- ready  output  1  high only in IDLE
- busy  output  1  high in LOAD, TEST, SHIFT
- load  output  1  datapath loads multiplicand and initial product
- add_product  output  1  datapath adds multiplicand into the product upper half
- shift_right  output  1  datapath shifts the product register right by 1
- write  output  1  product register write enable
- done  output  1  result valid; held until ack
- iter  output  CNT_W  current iteration index

Behaviour:
- Reset (clr=1 at a clock edge):
  - State goes to IDLE and iter goes to 0.
  - Outputs decode to ready=1 and all others 0.
  - clr overrides every other input, including mid-operation.
- Outputs are decoded from the state register, except add_product, which is state TEST AND product_0.
- IDLE:
  - ready=1.
  - start=1 -> LOAD; otherwise stay in IDLE.
- LOAD:
  - load=1, write=1; iter cleared to 0.
  - Next state TEST.
- TEST:
  - If product_0=1: add_product=1 and write=1. Otherwise no datapath strobes.
  - Next state SHIFT.
- SHIFT:
  - shift_right=1, write=1.
  - If iter==WIDTH-1 -> DONE, with iter held.
  - Otherwise iter<=iter+1 and next state TEST.
- DONE:
  - done=1.
  - ack=1 -> IDLE; otherwise hold done.
- Latency:
  - The edge that samples start in IDLE is edge 0.
  - done rises after edge 1+2*WIDTH (edge 65 for WIDTH=32).
  - ready returns on the edge after the ack is sampled.
- Strobe counts per operation:
  - load: exactly 1 cycle.
  - shift_right: exactly WIDTH cycles.
  - add_product: one cycle per TEST state with product_0=1.
- Exclusivity: add_product and shift_right are never high in the same cycle; load is never high with either.
- abort=1 in LOAD, TEST, SHIFT or DONE -> IDLE next edge:
  - No further strobes are issued and done drops.
  - iter is not cleared until the next LOAD.
  - abort in IDLE has no effect.
- Priority: clr > abort > ack/start.
- start while not IDLE is ignored, not queued.
- ack outside DONE is ignored.
- start and ack together in DONE: go to IDLE; start is not accepted that cycle.
- X on product_0 outside TEST must not affect state or outputs.

Test Plan:
- Reset: hold clr=1 for 2 cycles with start=1 -> ready=1, busy=0, done=0, all strobes 0, iter=0; no LOAD until clr=0.
- Basic run (WIDTH=4), product_0 sequence 1,0,1,1 across the TEST cycles, start pulsed 1 cycle:
  - load high for 1 cycle.
  - add_product high in TEST iterations 0, 2, 3 only (3 pulses).
  - shift_right high 4 times.
  - done rises after edge 9.
  - iter reads 0,1,2,3.
- Done hold (WIDTH=4): withhold ack for 5 cycles -> done stays 1 and no strobes; assert ack -> next edge ready=1, done=0.
- Abort (WIDTH=4): abort in the SHIFT of iter=1 -> IDLE next edge, no further strobes, done never rises; a new start then gives a full 4-iteration run with iter restarting at 0.
- Ignored inputs: start pulses while busy, and ack while busy -> timing identical to the basic run; exactly one operation completes.
- Mid-run reset plus default width:
  - clr=1 during TEST with product_0=1 -> next edge IDLE, add_product=0, iter=0.
  - WIDTH=32 run with product_0 constantly 1 -> 32 add pulses, done after edge 65.

Source files
------------

// File: rtl/mult_seq_ctrl_if.sv
// rtl/mult_seq_ctrl_if.sv - issue-side/datapath-side signal bundle for the shift-add multiplier sequencer
interface mult_seq_ctrl_if #(
    parameter int CNT_W = 5
);
    logic             start;
    logic             ack;
    logic             abort;
    logic             product_0;
    logic             ready;
    logic             busy;
    logic             load;
    logic             add_product;
    logic             shift_right;
    logic             write;
    logic             done;
    logic [CNT_W-1:0] iter;

    modport master (
        output start, ack, abort, product_0,
        input  ready, busy, load, add_product, shift_right, write, done, iter
    );

    modport slave (
        input  start, ack, abort, product_0,
        output ready, busy, load, add_product, shift_right, write, done, iter
    );
endinterface

// File: rtl/mult_seq_ctrl.sv
// rtl/mult_seq_ctrl.sv - shift-add multiplier sequencer: load, WIDTH test/shift iterations, done/ack
module mult_seq_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input logic           clk,
    input logic           clr,
    mult_seq_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_TEST,
        S_SHIFT,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_iter;
    logic             r_ready;
    logic             r_busy;
    logic             r_load;
    logic             r_shift;
    logic             r_done;
    logic             w_last;
    logic             w_add;

    assign w_last = (r_iter == LAST_ITER);

    always_comb begin
        w_state_nxt = r_state;
        if (bus.abort && r_state != S_IDLE) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (bus.start) w_state_nxt = S_LOAD;
                S_LOAD:  w_state_nxt = S_TEST;
                S_TEST:  w_state_nxt = S_SHIFT;
                S_SHIFT: w_state_nxt = w_last ? S_DONE : S_TEST;
                S_DONE:  if (bus.ack) w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Outputs are registered from the next state so they match a decode of r_state.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_state <= S_IDLE;
            r_iter  <= '0;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_load  <= 1'b0;
            r_shift <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ready <= (w_state_nxt == S_IDLE);
            r_busy  <= (w_state_nxt == S_LOAD) || (w_state_nxt == S_TEST) ||
                       (w_state_nxt == S_SHIFT);
            r_load  <= (w_state_nxt == S_LOAD);
            r_shift <= (w_state_nxt == S_SHIFT);
            r_done  <= (w_state_nxt == S_DONE);
            if (r_state == S_LOAD) begin
                r_iter <= '0;
            end else if (r_state == S_SHIFT && w_state_nxt == S_TEST) begin
                r_iter <= r_iter + 1'b1;
            end
        end
    end

    // Gate product_0 by state so an undriven LSB outside TEST cannot leak through.
    assign w_add = (r_state == S_TEST) ? bus.product_0 : 1'b0;

    assign bus.ready       = r_ready;
    assign bus.busy        = r_busy;
    assign bus.load        = r_load;
    assign bus.add_product = w_add;
    assign bus.shift_right = r_shift;
    assign bus.write       = r_load | r_shift | w_add;
    assign bus.done        = r_done;
    assign bus.iter        = r_iter;
endmodule

// File: tb/tb_mult_seq_ctrl.sv
// tb/tb_mult_seq_ctrl.sv - table-driven bench for mult_seq_ctrl at WIDTH=4 and WIDTH=32
module tb_mult_seq_ctrl;
    logic clk = 1'b0;
    logic clr = 1'b1;

    always #5 clk = ~clk;

    mult_seq_ctrl_if #(.CNT_W(2)) if4 ();
    mult_seq_ctrl_if #(.CNT_W(5)) if32 ();

    mult_seq_ctrl #(.WIDTH(4), .CNT_W(2)) dut4 (
        .clk (clk),
        .clr (clr),
        .bus (if4.slave)
    );

    mult_seq_ctrl #(.WIDTH(32), .CNT_W(5)) dut32 (
        .clk (clk),
        .clr (clr),
        .bus (if32.slave)
    );

    // flag order: {ready, busy, load, add_product, shift_right, write, done}
    localparam logic [6:0] F_IDLE = 7'b1000000;
    localparam logic [6:0] F_LOAD = 7'b0110010;
    localparam logic [6:0] F_TA   = 7'b0101010;
    localparam logic [6:0] F_T0   = 7'b0100000;
    localparam logic [6:0] F_SH   = 7'b0100110;
    localparam logic [6:0] F_DONE = 7'b0000001;

    typedef struct {
        logic       clr;
        logic       start;
        logic       ack;
        logic       abort;
        logic       p0;
        logic [6:0] flags;
        int         iter;
    } vec_t;

    vec_t tbl[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input int idx, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s[%0d] got=%0h expected=%0h", name, idx, got, exp);
        end
    endtask

    task automatic add(input logic c, input logic s, input logic a, input logic ab,
                       input logic p, input logic [6:0] f, input int it);
        vec_t v;
        v.clr = c; v.start = s; v.ack = a; v.abort = ab; v.p0 = p;
        v.flags = f; v.iter = it;
        tbl.push_back(v);
    endtask

    task automatic build_basic();
        add(0, 1, 0, 0, 1, F_IDLE, -1);
        add(0, 0, 0, 0, 1, F_LOAD, -1);
        add(0, 0, 0, 0, 1, F_TA,    0);
        add(0, 0, 0, 0, 1, F_SH,    0);
        add(0, 0, 0, 0, 0, F_T0,    1);
        add(0, 0, 0, 0, 1, F_SH,    1);
        add(0, 0, 0, 0, 1, F_TA,    2);
        add(0, 0, 0, 0, 0, F_SH,    2);
        add(0, 0, 0, 0, 1, F_TA,    3);
        add(0, 0, 0, 0, 1, F_SH,    3);
        for (int i = 0; i < 5; i++) add(0, 0, 0, 0, 1, F_DONE, 3);
        add(0, 0, 1, 0, 1, F_DONE, 3);
        add(0, 0, 0, 0, 1, F_IDLE, 3);
    endtask

    // Entered #1 after a rising edge; leaves #1 after the edge that ends the last row.
    task automatic run_tbl(input string name, input bit noise);
        logic [6:0] got;
        for (int i = 0; i < tbl.size(); i++) begin
            clr           = tbl[i].clr;
            if4.start     = tbl[i].start;
            if4.ack       = tbl[i].ack;
            if4.abort     = tbl[i].abort;
            if4.product_0 = tbl[i].p0;
            if (noise) begin
                if (i >= 1 && i <= 15) if4.start = 1'b1;
                if (i >= 1 && i <= 9)  if4.ack   = 1'b1;
            end
            @(negedge clk);
            got = {if4.ready, if4.busy, if4.load, if4.add_product,
                   if4.shift_right, if4.write, if4.done};
            chk({name, "_flags"}, i, 32'(got), 32'(tbl[i].flags));
            if (tbl[i].iter >= 0) chk({name, "_iter"}, i, 32'(if4.iter), 32'(tbl[i].iter));
            @(posedge clk);
            #1;
        end
        clr = 1'b0;
        if4.start = 1'b0; if4.ack = 1'b0; if4.abort = 1'b0;
        tbl.delete();
    endtask

    initial begin
        int first_done, n_load, n_add, n_shift, n_excl;
        if4.start = 0;  if4.ack = 0;  if4.abort = 0;  if4.product_0 = 0;
        if32.start = 0; if32.ack = 0; if32.abort = 0; if32.product_0 = 1;
        @(posedge clk);
        #1;

        add(1, 1, 0, 0, 1, F_IDLE, 0);
        add(1, 1, 0, 0, 1, F_IDLE, 0);
        add(0, 0, 0, 0, 1, F_IDLE, 0);
        add(0, 0, 0, 0, 1, F_IDLE, 0);
        run_tbl("reset", 0);

        build_basic();
        run_tbl("basic", 0);

        add(0, 1, 0, 0, 0, F_IDLE, -1);
        add(0, 0, 0, 0, 0, F_LOAD, -1);
        add(0, 0, 0, 0, 0, F_T0,    0);
        add(0, 0, 0, 0, 1, F_SH,    0);
        add(0, 0, 0, 0, 1, F_TA,    1);
        add(0, 0, 0, 1, 1, F_SH,    1);
        for (int i = 0; i < 4; i++) add(0, 0, 0, 0, 1, F_IDLE, -1);
        add(0, 0, 0, 1, 1, F_IDLE, -1);
        add(0, 0, 0, 0, 1, F_IDLE, -1);
        run_tbl("abort", 0);

        build_basic();
        run_tbl("rerun", 0);

        build_basic();
        run_tbl("ignored", 1);

        add(0, 1, 0, 0, 1, F_IDLE, -1);
        add(0, 0, 0, 0, 1, F_LOAD, -1);
        add(1, 0, 0, 0, 1, F_TA,    0);
        add(0, 0, 0, 0, 1, F_IDLE,  0);
        add(0, 0, 0, 0, 1, F_IDLE,  0);
        run_tbl("midclr", 0);

        first_done = -1; n_load = 0; n_add = 0; n_shift = 0; n_excl = 0;
        if32.start = 1'b1;
        for (int cyc = 0; cyc < 200; cyc++) begin
            @(negedge clk);
            if (if32.done) begin
                first_done = cyc;
                break;
            end
            n_load  += int'(if32.load);
            n_add   += int'(if32.add_product);
            n_shift += int'(if32.shift_right);
            if ((if32.add_product && if32.shift_right) ||
                (if32.load && (if32.add_product || if32.shift_right))) n_excl++;
            @(posedge clk);
            #1;
            if32.start = 1'b0;
        end
        chk("w32_done_cycle", 0, 32'(first_done), 32'd66);
        chk("w32_loads",      0, 32'(n_load),     32'd1);
        chk("w32_adds",       0, 32'(n_add),      32'd32);
        chk("w32_shifts",     0, 32'(n_shift),    32'd32);
        chk("w32_exclusive",  0, 32'(n_excl),     32'd0);
        chk("w32_iter",       0, 32'(if32.iter),  32'd31);
        @(posedge clk);
        #1;
        if32.ack = 1'b1;
        @(posedge clk);
        #1;
        if32.ack = 1'b0;
        @(negedge clk);
        chk("w32_ready_after_ack", 0, {30'd0, if32.ready, if32.done}, 32'b10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
